// File: rtl/verify_cmp_pkg.sv
// Shared widths, default region layout and FSM encoding for the constant-time region compare.
package verify_cmp_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 9;

  // Default layout: re-encrypted ciphertext at 0, received ciphertext at 168, 136 words each.
  localparam logic [ADDR_W-1:0] DEF_BASE_A    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] DEF_BASE_B    = ADDR_W'(168);
  localparam logic [CNT_W-1:0]  DEF_NUM_WORDS = CNT_W'(136);

  typedef enum logic [1:0] {
    ST_RUN_A = 2'd0,
    ST_RUN_B = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/verify_cmp.sv
// Constant-time equality check of two equal-length 64-bit word regions.
// Reads alternate A,B one address per cycle; the XOR difference is OR-accumulated
// with no data-dependent control, and the verdict is published once at the end.
module verify_cmp
  import verify_cmp_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_A    = DEF_BASE_A,
  parameter logic [ADDR_W-1:0] BASE_B    = DEF_BASE_B,
  parameter logic [CNT_W-1:0]  NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic              verify_true,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST_IDX = NUM_WORDS - CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   reg_a_q, reg_a_d;
  logic [DATA_W-1:0]   diff_q, diff_d;
  logic [DATA_W-1:0]   diff_acc;
  logic [ADDR_W-1:0]   addr_d;
  logic                done_d;
  logic                verify_d;

  // Next-state, address sequencing and accumulate; every path does the same work regardless of data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reg_a_d  = reg_a_q;
    diff_d   = diff_q;
    addr_d   = read_address;
    done_d   = done;
    verify_d = verify_true;
    diff_acc = diff_q | (reg_a_q ^ read_data);

    unique case (state_q)
      ST_RUN_A: begin
        // read_data holds B word cnt-1 here, except on the very first A read.
        if (cnt_q != CNT_W'(0)) diff_d = diff_acc;
        addr_d  = BASE_B + ADDR_W'(cnt_q);
        state_d = ST_RUN_B;
      end
      ST_RUN_B: begin
        reg_a_d = read_data;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_LAST;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          addr_d  = BASE_A + ADDR_W'(cnt_q + CNT_W'(1));
          state_d = ST_RUN_A;
        end
      end
      ST_LAST: begin
        diff_d   = diff_acc;
        done_d   = 1'b1;
        verify_d = ~|diff_acc;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts and rearms a full rerun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN_A;
      cnt_q        <= '0;
      reg_a_q      <= '0;
      diff_q       <= '0;
      read_address <= BASE_A;
      done         <= 1'b0;
      verify_true  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_a_q      <= reg_a_d;
      diff_q       <= diff_d;
      read_address <= addr_d;
      done         <= done_d;
      verify_true  <= verify_d;
    end
  end

endmodule

// File: tb/tb_verify_cmp.sv
// Scoreboard bench for verify_cmp: a default-layout instance and a one-word instance share a
// registered memory model; expected address traces and verdicts are queued at stimulus time.
module tb_verify_cmp;
  import verify_cmp_pkg::*;

  typedef struct {
    int cyc;
    bit vt;
  } exp_res_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic vt0, vt1, done0, done1;

  logic [DATA_W-1:0] mem [0:511];

  logic              sel;
  logic [ADDR_W-1:0] cur_base_a;
  logic              m_rst, m_vt, m_done;
  logic [ADDR_W-1:0] m_addr;

  logic [ADDR_W-1:0] exp_addr_q [$];
  exp_res_t          exp_res_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  verify_cmp dut (
    .clk(clk), .rst(rst0), .read_address(addr0), .read_data(rdata0),
    .verify_true(vt0), .done(done0)
  );

  verify_cmp #(.BASE_A(9'd5), .BASE_B(9'd9), .NUM_WORDS(9'd1)) dut_small (
    .clk(clk), .rst(rst1), .read_address(addr1), .read_data(rdata1),
    .verify_true(vt1), .done(done1)
  );

  // Registered RAM read ports, one cycle of latency.
  always @(posedge clk) begin
    rdata0 <= mem[addr0];
    rdata1 <= mem[addr1];
  end

  assign m_rst  = sel ? rst1  : rst0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_vt   = sel ? vt1   : vt0;
  assign m_done = sel ? done1 : done0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int k);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, k, $time);
    end
  endtask

  // Monitor: compares the selected instance once per cycle, on the falling edge.
  int       k = 0;
  bit       seen_done = 1'b0;
  bit       exp_vt = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  always @(negedge clk) begin
    exp_res_t r;
    if (m_rst) begin
      k = 0;
      seen_done = 1'b0;
      chk("rst_addr", 64'(m_addr), 64'(cur_base_a), k);
      chk("rst_done", 64'(m_done), 64'd0, k);
      chk("rst_verify", 64'(m_vt), 64'd0, k);
    end else begin
      if (exp_addr_q.size() > 0) begin
        last_addr = exp_addr_q.pop_front();
        chk("addr", 64'(m_addr), 64'(last_addr), k);
      end else begin
        chk("addr_hold", 64'(m_addr), 64'(last_addr), k);
      end
      if (!seen_done) begin
        if (m_done) begin
          if (exp_res_q.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0, k);
          end else begin
            r = exp_res_q.pop_front();
            chk("done_cycle", 64'(k), 64'(r.cyc), k);
            chk("verify_true", 64'(m_vt), 64'(r.vt), k);
            exp_vt = r.vt;
          end
          seen_done = 1'b1;
        end else begin
          chk("verify_before_done", 64'(m_vt), 64'd0, k);
        end
      end else begin
        chk("done_held", 64'(m_done), 64'd1, k);
        chk("verify_stable", 64'(m_vt), 64'(exp_vt), k);
      end
      k++;
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic fill_equal(input int ba, input int bb, input int n);
    for (int i = 0; i < n; i++) begin
      mem[ba+i] = rnd64();
      mem[bb+i] = mem[ba+i];
    end
  endtask

  // Queue the reference trace and verdict, then release reset on the selected instance.
  task automatic start_run(input bit s, input int n, input int ba, input int bb);
    exp_res_t r;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(ADDR_W'(ba + i));
      exp_addr_q.push_back(ADDR_W'(bb + i));
    end
    r.cyc = 2 * n + 1;
    r.vt  = 1'b1;
    for (int i = 0; i < n; i++) if (mem[ba+i] != mem[bb+i]) r.vt = 1'b0;
    exp_res_q.push_back(r);
    sel = s;
    cur_base_a = ADDR_W'(ba);
    @(posedge clk); #1;
    if (s) rst1 = 1'b0; else rst0 = 1'b0;
  endtask

  // Bounded wait past the expected completion plus a stability window, then re-assert reset.
  task automatic finish_run(input int n);
    repeat (2 * n + 25) @(posedge clk);
    #1;
    chk("result_consumed", 64'(exp_res_q.size()), 64'd0, -1);
    chk("trace_consumed", 64'(exp_addr_q.size()), 64'd0, -1);
    exp_res_q.delete();
    exp_addr_q.delete();
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam int NW = 136;
  localparam int BA = 0;
  localparam int BB = 168;

  initial begin
    int w, b;
    rst0 = 1'b1;
    rst1 = 1'b1;
    sel = 1'b0;
    cur_base_a = ADDR_W'(BA);
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;

    // Identical regions.
    fill_equal(BA, BB, NW);
    start_run(1'b0, NW, BA, BB);
    finish_run(NW);

    // Last B word differs in bit 63.
    fill_equal(BA, BB, NW);
    mem[BB+NW-1][63] = ~mem[BB+NW-1][63];
    start_run(1'b0, NW, BA, BB);
    finish_run(NW);

    // First B word differs in bit 0.
    fill_equal(BA, BB, NW);
    mem[BB][0] = ~mem[BB][0];
    start_run(1'b0, NW, BA, BB);
    finish_run(NW);

    // Abort a mismatching run at cycle 100, make memory identical, rerun.
    fill_equal(BA, BB, NW);
    mem[BB+20] = ~mem[BB+20];
    start_run(1'b0, NW, BA, BB);
    repeat (100) @(posedge clk);
    #1;
    rst0 = 1'b1;
    exp_addr_q.delete();
    exp_res_q.delete();
    repeat (2) @(posedge clk);
    #1;
    mem[BB+20] = mem[BA+20];
    start_run(1'b0, NW, BA, BB);
    finish_run(NW);

    // Single-word instance at 5/9.
    fill_equal(5, 9, 1);
    start_run(1'b1, 1, 5, 9);
    finish_run(1);

    // All-zero A versus all-ones B.
    for (int i = 0; i < NW; i++) begin
      mem[BA+i] = '0;
      mem[BB+i] = '1;
    end
    start_run(1'b0, NW, BA, BB);
    finish_run(NW);

    // Random equal/single-bit-flip runs.
    for (int r = 0; r < 3; r++) begin
      fill_equal(BA, BB, NW);
      if ($urandom_range(0, 1) == 1) begin
        w = int'($urandom_range(0, NW - 1));
        b = int'($urandom_range(0, 63));
        mem[BB+w][b] = ~mem[BB+w][b];
      end
      start_run(1'b0, NW, BA, BB);
      finish_run(NW);
    end

    // Single-word instance with a mismatch.
    fill_equal(5, 9, 1);
    mem[9][31] = ~mem[9][31];
    start_run(1'b1, 1, 5, 9);
    finish_run(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
